// File: rtl/cache_pkg.sv
// Shared cache geometry and fill-FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: column/zero/line index widths shared with the cache, fill state enum.
package cache_pkg;

  localparam int ADDR_BITWIDTH      = 32;
  localparam int COLUMN_IX_BITWIDTH = 2;
  localparam int ZEROS_BITWIDTH     = 2;
  localparam int LINE_IX_BITWIDTH   = 6;

  typedef enum logic [2:0] {
    FILL_IDLE,
    FILL_CMD,
    FILL_RECV,
    FILL_DONE,
    FILL_ABORT
  } fill_state_t;

endpackage

// File: rtl/cache_line_filler_if.sv
// Bundle of core-miss, memory-burst and cache-write signals around the filler.
// Latency: n/a (wiring only).
// Backpressure: miss_valid/miss_ready and mem_cmd_valid/mem_cmd_ready handshakes; read beats have none.
// Modports: slave = the line filler, master = the core/memory/cache environment.
interface cache_line_filler_if;

  logic        miss_valid;
  logic [31:0] miss_address;
  logic        miss_ready;
  logic [31:0] fwd_data;
  logic        fwd_valid;
  logic        fill_done;
  logic        fill_error;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [31:0] mem_cmd_address;
  logic [31:0] mem_rd_data;
  logic        mem_rd_data_valid;
  logic [31:0] cache_address;
  logic [31:0] cache_data_in;
  logic        cache_write_enable;

  modport slave (
    input  miss_valid, miss_address, mem_cmd_ready, mem_rd_data, mem_rd_data_valid,
    output miss_ready, fwd_data, fwd_valid, fill_done, fill_error,
           mem_cmd_valid, mem_cmd_address, cache_address, cache_data_in, cache_write_enable
  );

  modport master (
    output miss_valid, miss_address, mem_cmd_ready, mem_rd_data, mem_rd_data_valid,
    input  miss_ready, fwd_data, fwd_valid, fill_done, fill_error,
           mem_cmd_valid, mem_cmd_address, cache_address, cache_data_in, cache_write_enable
  );

endinterface

// File: rtl/cache_line_filler_fill_timeout_counter.sv
// Idle-cycle counter used to abort a fill when memory stops responding.
// Latency: expired flag is combinational from the registered count.
// Backpressure: none; clear has priority over increment.
// Ports: clk, rst_n, i_clr, i_inc, o_expired (count has reached LIMIT-1).
module fill_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag one count early so that the increment happening in this cycle is the
  // LIMIT-th idle cycle; the FSM qualifies it with its own increment request.
  assign o_expired = (r_cnt == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/cache_line_filler.sv
// Refill engine: one miss -> one line-sized burst read -> cache writes + critical word forward.
// Latency: each read beat is written to the cache exactly 1 cycle after it arrives.
// Backpressure: miss_ready only in IDLE (other misses ignored); beats have no backpressure.
// Ports: clk, rst_n, bus (cache_line_filler_if.slave).
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the wrapping burst at the requested column.
module cache_line_filler
  import cache_pkg::*;
#(
  parameter int COLUMN_IX_BITWIDTH = cache_pkg::COLUMN_IX_BITWIDTH,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_line_filler_if.slave bus
);

  localparam int BASE_BITWIDTH = ADDR_BITWIDTH - COLUMN_IX_BITWIDTH - ZEROS_BITWIDTH;
  localparam int BEATS         = 2 ** COLUMN_IX_BITWIDTH;
  localparam logic [COLUMN_IX_BITWIDTH:0] LAST_BEAT = (COLUMN_IX_BITWIDTH + 1)'(BEATS);

  fill_state_t                   r_state;
  fill_state_t                   w_state_nxt;
  logic [BASE_BITWIDTH-1:0]      r_base;
  logic [COLUMN_IX_BITWIDTH-1:0] r_req_col;
  logic [COLUMN_IX_BITWIDTH-1:0] r_wr_col;
  logic [COLUMN_IX_BITWIDTH:0]   r_rx_cnt;
  logic [31:0]                   r_beat_dat;
  logic                          r_beat_vld;

  logic                          w_miss_acc;
  logic                          w_beat_acc;
  logic                          w_tmo_inc;
  logic                          w_tmo_clr;
  logic                          w_tmo_expired;
  logic                          w_last_wr;
  logic [COLUMN_IX_BITWIDTH-1:0] w_miss_col;
  logic [COLUMN_IX_BITWIDTH-1:0] w_start_col;

  assign w_miss_col = bus.miss_address[ZEROS_BITWIDTH +: COLUMN_IX_BITWIDTH];

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign w_start_col         = w_miss_col;
  assign bus.mem_cmd_address = {r_base, r_req_col, {ZEROS_BITWIDTH{1'b0}}};
`else
  assign w_start_col         = '0;
  assign bus.mem_cmd_address = {r_base, {COLUMN_IX_BITWIDTH{1'b0}}, {ZEROS_BITWIDTH{1'b0}}};
`endif

  // The 4th registered beat is being written this cycle.
  assign w_last_wr = r_beat_vld && (r_rx_cnt == LAST_BEAT);

  fill_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (8)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmo_clr),
    .i_inc     (w_tmo_inc),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_miss_acc  = 1'b0;
    w_beat_acc  = 1'b0;
    w_tmo_inc   = 1'b0;
    w_tmo_clr   = 1'b1;
    case (r_state)
      FILL_IDLE: begin
        if (bus.miss_valid) begin
          w_miss_acc  = 1'b1;
          w_state_nxt = FILL_CMD;
        end
      end
      FILL_CMD: begin
        if (bus.mem_cmd_ready) begin
          w_state_nxt = FILL_RECV;
        end else begin
          w_tmo_clr = 1'b0;
          w_tmo_inc = 1'b1;
          if (w_tmo_expired) w_state_nxt = FILL_ABORT;
        end
      end
      FILL_RECV: begin
        // Beats beyond the line length are not captured, so they cannot
        // produce a fifth write.
        if (bus.mem_rd_data_valid && (r_rx_cnt != LAST_BEAT)) begin
          w_beat_acc = 1'b1;
        end else begin
          w_tmo_clr = 1'b0;
          w_tmo_inc = 1'b1;
          if (w_tmo_expired) w_state_nxt = FILL_ABORT;
        end
        if (w_last_wr) w_state_nxt = FILL_DONE;
      end
      FILL_DONE:  w_state_nxt = FILL_IDLE;
      FILL_ABORT: w_state_nxt = FILL_IDLE;
      default:    w_state_nxt = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_req_col  <= '0;
      r_wr_col   <= '0;
      r_rx_cnt   <= '0;
      r_beat_dat <= '0;
      r_beat_vld <= 1'b0;
    end else begin
      r_beat_vld <= w_beat_acc;
      if (w_beat_acc) r_beat_dat <= bus.mem_rd_data;
      if (w_miss_acc) begin
        r_base    <= bus.miss_address[ADDR_BITWIDTH-1 -: BASE_BITWIDTH];
        r_req_col <= w_miss_col;
        r_wr_col  <= w_start_col;
        r_rx_cnt  <= '0;
      end else begin
        if (w_beat_acc) r_rx_cnt <= r_rx_cnt + 1'b1;
        // Column wraps naturally modulo the line length.
        if (r_beat_vld) r_wr_col <= r_wr_col + 1'b1;
      end
    end
  end

  assign bus.miss_ready         = (r_state == FILL_IDLE);
  assign bus.mem_cmd_valid      = (r_state == FILL_CMD);
  assign bus.fill_done          = (r_state == FILL_DONE);
  assign bus.fill_error         = (r_state == FILL_ABORT);
  assign bus.cache_write_enable = r_beat_vld;
  assign bus.cache_address      = {r_base, r_wr_col, {ZEROS_BITWIDTH{1'b0}}};
  assign bus.cache_data_in      = r_beat_dat;
  assign bus.fwd_valid          = r_beat_vld && (r_wr_col == r_req_col);
  assign bus.fwd_data           = r_beat_dat;

endmodule

// File: tb/tb_cache_line_filler.sv
module tb_cache_line_filler;

  localparam int TMO = 255;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  int   n_fwd = 0;
  logic [31:0] last_fwd = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_line_filler_if bus_if ();

  cache_line_filler #(
    .COLUMN_IX_BITWIDTH (2),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        f;
    int          c;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] d0;
    int          delay;
    int          gap;
    bit          extra;
    logic [31:0] exp_cmd;
    logic [31:0] exp_fwd;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cache-write scoreboard and event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_if.fill_done && bus_if.fill_error) chk("done_and_error", bus_if.fill_error, 1'b0);
    if (bus_if.fwd_valid) begin
      n_fwd++;
      last_fwd = bus_if.fwd_data;
      if (!bus_if.cache_write_enable) chk("fwd_without_write", bus_if.cache_write_enable, 1'b1);
    end
    if (bus_if.cache_write_enable) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus_if.cache_write_enable, 1'b0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus_if.cache_address, e.a);
        chk("wr_data", bus_if.cache_data_in, e.d);
        chk("wr_fwd_valid", bus_if.fwd_valid, e.f);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input vec_t v);
    chk("miss_ready_idle", bus_if.miss_ready, 1'b1);
    bus_if.miss_valid   = 1'b1;
    bus_if.miss_address = v.addr;
    step();
    bus_if.miss_valid = 1'b0;
    for (int i = 0; i < v.delay; i++) begin
      chk("cmd_valid_wait", bus_if.mem_cmd_valid, 1'b1);
      chk("cmd_addr_wait", bus_if.mem_cmd_address, v.exp_cmd);
      chk("miss_ready_cmd", bus_if.miss_ready, 1'b0);
      step();
    end
    chk("cmd_valid", bus_if.mem_cmd_valid, 1'b1);
    chk("cmd_addr", bus_if.mem_cmd_address, v.exp_cmd);
    bus_if.mem_cmd_ready = 1'b1;
    step();
    bus_if.mem_cmd_ready = 1'b0;
    chk("cmd_valid_after_hs", bus_if.mem_cmd_valid, 1'b0);
  endtask

  task automatic drive_beat(input vec_t v, input int i, output int k);
    wr_t e;
    logic [1:0] sc, col;
    sc  = CWF ? v.addr[3:2] : 2'd0;
    col = sc + 2'(i);
    bus_if.mem_rd_data_valid = 1'b1;
    bus_if.mem_rd_data       = v.d0 + 32'(i);
    e.a = {v.addr[31:4], col, 2'b00};
    e.d = v.d0 + 32'(i);
    e.f = (col == v.addr[3:2]);
    e.c = cyc + 1;
    exp_q.push_back(e);
    k = cyc;
    step();
    bus_if.mem_rd_data_valid = 1'b0;
  endtask

  task automatic do_fill(input vec_t v, input int nb);
    int  k_last, t_end;
    bit  got, done_seen, err_seen;
    n_fwd = 0;
    k_last = 0;
    start_fill(v);
    for (int i = 0; i < nb; i++) begin
      drive_beat(v, i, k_last);
      if (i == 0 && v.extra) begin
        chk("miss_ready_recv", bus_if.miss_ready, 1'b0);
        bus_if.miss_valid   = 1'b1;
        bus_if.miss_address = 32'h5555_0000;
        step();
        bus_if.miss_valid = 1'b0;
      end
      if (i < nb - 1) repeat (v.gap) step();
    end
    got = 0; done_seen = 0; err_seen = 0; t_end = 0;
    for (int t = 0; t < 600 && !got; t++) begin
      if (bus_if.fill_done || bus_if.fill_error) begin
        got = 1;
        t_end = cyc;
        done_seen = bus_if.fill_done;
        err_seen = bus_if.fill_error;
      end else begin
        step();
      end
    end
    chk("fill_end_seen", got, 1'b1);
    if (nb == 4) begin
      chk("fill_done", done_seen, 1'b1);
      chk("no_error", err_seen, 1'b0);
      chk("done_cycle", t_end, k_last + 2);
      chk("fwd_count", n_fwd, 1);
      chk("fwd_data", last_fwd, v.exp_fwd);
    end else begin
      chk("fill_error", err_seen, 1'b1);
      chk("no_done", done_seen, 1'b0);
      chk("error_cycle", t_end, k_last + TMO + 1);
    end
    chk("miss_ready_end", bus_if.miss_ready, 1'b0);
    step();
    chk("miss_ready_after", bus_if.miss_ready, 1'b1);
    chk("cmd_valid_idle", bus_if.mem_cmd_valid, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt, vr, vp;
    int   k, wr_before;
    bus_if.miss_valid        = 1'b0;
    bus_if.miss_address      = '0;
    bus_if.mem_cmd_ready     = 1'b0;
    bus_if.mem_rd_data       = '0;
    bus_if.mem_rd_data_valid = 1'b0;

    vecs[0] = '{32'h0000_1238, 32'h0000_00A0, 0, 0, 1'b0,
                CWF ? 32'h0000_1238 : 32'h0000_1230, CWF ? 32'h0000_00A0 : 32'h0000_00A2};
    vecs[1] = '{32'hFFFF_FFF4, 32'h1000_0000, 10, 3, 1'b1,
                CWF ? 32'hFFFF_FFF4 : 32'hFFFF_FFF0, CWF ? 32'h1000_0000 : 32'h1000_0001};
    vecs[2] = '{32'h8000_000C, 32'hDEAD_BEE0, 2, 1, 1'b0,
                CWF ? 32'h8000_000C : 32'h8000_0000, CWF ? 32'hDEAD_BEE0 : 32'hDEAD_BEE3};
    vecs[3] = '{32'h1234_5673, 32'h0000_0050, 0, 0, 1'b0, 32'h1234_5670, 32'h0000_0050};
    vt = '{32'h2000_0008, 32'h0000_00B0, 0, 0, 1'b0,
           CWF ? 32'h2000_0008 : 32'h2000_0000, 32'h0};
    vr = '{32'h0000_3004, 32'h0000_00E0, 0, 0, 1'b0,
           CWF ? 32'h0000_3004 : 32'h0000_3000, 32'h0};
    vp = '{32'h0000_0004, 32'h0000_00C0, 1, 0, 1'b0,
           CWF ? 32'h0000_0004 : 32'h0000_0000, CWF ? 32'h0000_00C0 : 32'h0000_00C1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_miss_ready", bus_if.miss_ready, 1'b1);
    chk("rst_cmd_valid", bus_if.mem_cmd_valid, 1'b0);
    chk("rst_cmd_addr", bus_if.mem_cmd_address, 32'h0);
    chk("rst_write_enable", bus_if.cache_write_enable, 1'b0);
    chk("rst_fwd_valid", bus_if.fwd_valid, 1'b0);
    chk("rst_fill_done", bus_if.fill_done, 1'b0);
    chk("rst_fill_error", bus_if.fill_error, 1'b0);
    chk("rst_cache_addr", bus_if.cache_address, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) do_fill(vecs[i], 4);

    // Memory delivers two beats and then goes silent.
    do_fill(vt, 2);

    // Reset while the second beat is being written.
    start_fill(vr);
    drive_beat(vr, 0, k);
    drive_beat(vr, 1, k);
    chk("we_before_reset", bus_if.cache_write_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("we_async_reset", bus_if.cache_write_enable, 1'b0);
    chk("miss_ready_in_reset", bus_if.miss_ready, 1'b1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    wr_before = n_wr;
    bus_if.mem_rd_data_valid = 1'b1;
    bus_if.mem_rd_data       = 32'h0BAD_0BAD;
    repeat (2) step();
    bus_if.mem_rd_data_valid = 1'b0;
    step();
    chk("stray_writes", n_wr - wr_before, 0);
    do_fill(vp, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
